regfile_serial_reader: RTL and testbench

Initiator-side reader for the 4x8 register file. On a start request it walks every entry through the register file's read port (read_address out, read_data in). It transmits each captured byte as an asynchronous serial frame on one wire. It sits between the register file and an off-chip/debug link, so stored contents can be dumped without a parallel bus.

---
 rtl/regfile_reader_pkg.sv | 31 +++
 rtl/regfile_serial_reader_bit_timer.sv | 40 ++++
 rtl/regfile_serial_reader.sv | 141 ++++++++++++++
 tb/tb_regfile_serial_reader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_reader_pkg.sv
// Shared definitions for the register-file serial reader: FSM state codes,
// serial frame constants and the per-word cycle count.
// Optional feature macro: REGFILE_READER_PARITY_EN (even-parity bit per frame).
package regfile_reader_pkg;

  // FSM state codes
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef REGFILE_READER_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd5;
`endif
  localparam logic [2:0] ST_FINISH = 3'd6;

  // Serial line levels
  localparam logic FRAME_START_BIT = 1'b0;
  localparam logic FRAME_STOP_BIT  = 1'b1;
  localparam logic TX_IDLE         = 1'b1;

  // Clock cycles spent on one register entry: one FETCH cycle plus the frame
  function automatic int word_cycles(input int data_width, input int clks_per_bit);
`ifdef REGFILE_READER_PARITY_EN
    return 1 + (data_width + 3) * clks_per_bit;
`else
    return 1 + (data_width + 2) * clks_per_bit;
`endif
  endfunction

endpackage

// File: rtl/regfile_serial_reader_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick on
// the terminal count. With CLKS_PER_BIT=1 the counter is bypassed and every
// enabled cycle is a tick.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  generate
    if (CLKS_PER_BIT <= 1) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset, clear};
      assign tick = enable;
    end else begin : g_count
      localparam int CW = $clog2(CLKS_PER_BIT);
      localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

      logic [CW-1:0] cnt;

      // Free-running period counter, restarted by clear and wrapped on tick
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (enable) begin
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
      end

      assign tick = enable && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/regfile_serial_reader.sv
// Register-file serial reader: on start, fetches every register-file entry in
// address order and sends each byte as an async serial frame (start bit,
// DATA_WIDTH bits LSB first, stop bit) on tx, then pulses done.
// Optional feature macro: REGFILE_READER_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
module regfile_serial_reader
  import regfile_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 2,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [ADDR_WIDTH-1:0] read_address,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  logic [2:0]            state;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  tick;
  logic                  timer_clear;
  logic                  timer_en;
`ifdef REGFILE_READER_PARITY_EN
  logic                  parity;
`endif

  // The timer restarts on every FETCH so each frame's start bit gets a full period
  assign timer_clear = (state == ST_FETCH);
  assign timer_en    = (state != ST_IDLE) && (state != ST_FETCH) && (state != ST_FINISH);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .enable(timer_en),
    .tick  (tick)
  );

  // Sequencer: scan addresses, drive the serial line, track busy/done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      tx           <= TX_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      read_address <= '0;
      bit_cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= TX_IDLE;
          if (start) begin
            state        <= ST_FETCH;
            read_address <= '0;
            busy         <= 1'b1;
          end
        end
        ST_FETCH: begin
          state <= ST_START;
          tx    <= FRAME_START_BIT;
        end
        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            tx      <= shift_reg[0];
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef REGFILE_READER_PARITY_EN
              state <= ST_PARITY;
              tx    <= parity;
`else
              state <= ST_STOP;
              tx    <= FRAME_STOP_BIT;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_reg[0];
            end
          end
        end
`ifdef REGFILE_READER_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            tx    <= FRAME_STOP_BIT;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (read_address == LAST_ADDR) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state        <= ST_FETCH;
              read_address <= read_address + 1'b1;
            end
          end
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          tx    <= TX_IDLE;
        end
      endcase
    end
  end

  // Payload capture in FETCH; later register-file writes cannot touch the byte in flight
  always_ff @(posedge clk) begin
    if (state == ST_FETCH) begin
      shift_reg <= read_data;
`ifdef REGFILE_READER_PARITY_EN
      parity    <= ^read_data;
`endif
    end else if (tick && ((state == ST_START) || (state == ST_DATA))) begin
      shift_reg <= shift_reg >> 1;
    end
  end

endmodule

// File: tb/tb_regfile_serial_reader.sv
// Bench for regfile_serial_reader: a behavioural register file feeds the DUT,
// a serial decoder rebuilds each frame from tx and checks it against the
// expected-frame queue filled when each scan is launched.
module tb_regfile_serial_reader;
  import regfile_reader_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int CPB  = 4;
  localparam int WC   = word_cycles(DW, CPB);
  // Edges after the start edge at which FINISH is entered (done high until the next edge)
  localparam int SCAN = 4 * WC;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] read_data;
  logic [AW-1:0] read_address;
  logic          tx;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [4];
  assign read_data = mem[read_address];

  always #5 clk = ~clk;

  regfile_serial_reader #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .read_data   (read_data),
    .read_address(read_address),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Serial decoder: sample mid-bit on falling clock edges, abandon frames cut by reset
  always begin : rx
    logic [DW-1:0] b;
    logic [AW-1:0] a;
    logic          mid_start;
    logic          par;
    logic          stp;
    logic          aborted;
    frame_t        e;
    @(negedge clk);
    if (reset === 1'b1 && tx === 1'b0) begin
      aborted = 1'b0;
      a = read_address;
      b = '0;
      par = 1'b0;
      repeat (CPB / 2) begin @(negedge clk); if (reset !== 1'b1) aborted = 1'b1; end
      mid_start = tx;
      for (int i = 0; i < DW; i++) begin
        repeat (CPB) begin @(negedge clk); if (reset !== 1'b1) aborted = 1'b1; end
        b[i] = tx;
      end
`ifdef REGFILE_READER_PARITY_EN
      repeat (CPB) begin @(negedge clk); if (reset !== 1'b1) aborted = 1'b1; end
      par = tx;
`endif
      repeat (CPB) begin @(negedge clk); if (reset !== 1'b1) aborted = 1'b1; end
      stp = tx;
      if (!aborted) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected_frame: got data=%h addr=%0d, required no frame", b, a);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (b !== e.data) begin errors++; $display("FAIL rx_data: got %h, required %h", b, e.data); end
          checks++;
          if (a !== e.addr) begin errors++; $display("FAIL rx_addr: got %0d, required %0d", a, e.addr); end
          checks++;
          if (mid_start !== 1'b0 || stp !== 1'b1) begin
            errors++;
            $display("FAIL rx_framing: start=%b stop=%b, required start=0 stop=1", mid_start, stp);
          end
`ifdef REGFILE_READER_PARITY_EN
          checks++;
          if (par !== ^e.data) begin errors++; $display("FAIL rx_parity: got %b, required %b for %h", par, ^e.data, e.data); end
`endif
        end
      end
    end
  end

  task automatic load_mem(input logic [DW-1:0] d0, d1, d2, d3);
    mem[0] = d0; mem[1] = d1; mem[2] = d2; mem[3] = d3;
  endtask

  task automatic push_scan(input logic [DW-1:0] d0, d1, d2, d3);
    exp_q.push_back('{addr: 2'd0, data: d0});
    exp_q.push_back('{addr: 2'd1, data: d1});
    exp_q.push_back('{addr: 2'd2, data: d2});
    exp_q.push_back('{addr: 2'd3, data: d3});
  endtask

  // Pulse start for one edge; returns at the falling edge after the start edge
  task automatic fire_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    int tx_bad;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL rst_tx: got %b, required 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    checks++; if (read_address !== 2'd0) begin errors++; $display("FAIL rst_addr: got %0d, required 0", read_address); end
    reset = 1'b1;
    tx_bad = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) tx_bad++;
    end
    checks++; if (tx_bad != 0) begin errors++; $display("FAIL idle_quiet: %0d bad cycles, required 0", tx_bad); end
    checks++; if (read_address !== 2'd0) begin errors++; $display("FAIL idle_addr: got %0d, required 0", read_address); end
  endtask

  task automatic test_scan();
    int first_low, done_n, done_cnt, addr_bad, busy_bad;
    logic [AW-1:0] ea;
    load_mem(8'h55, 8'hA3, 8'h00, 8'hFF);
    push_scan(8'h55, 8'hA3, 8'h00, 8'hFF);
    first_low = -1; done_n = -1; done_cnt = 0; addr_bad = 0; busy_bad = 0;
    fire_start();
    for (int n = 0; n <= SCAN + 5; n++) begin
      if (n > 0) @(negedge clk);
      if (tx === 1'b0 && first_low < 0) first_low = n;
      if (done === 1'b1) begin done_cnt++; done_n = n; end
      ea = (n < SCAN) ? AW'(n / WC) : 2'd3;
      if (read_address !== ea) addr_bad++;
      if (busy !== ((n <= SCAN) ? 1'b1 : 1'b0)) busy_bad++;
    end
    // tx falls on the second edge counting the start edge itself
    checks++; if (first_low != 1) begin errors++; $display("FAIL scan_latency: tx low %0d edges after start edge, required 1", first_low); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL scan_done_count: got %0d, required 1", done_cnt); end
    // done spans edges SCAN..SCAN+1 after the start edge: 1 + 4*41 + 1 = 166 edges including the start edge
    checks++; if (done_n != SCAN) begin errors++; $display("FAIL scan_done_time: got %0d, required %0d", done_n, SCAN); end
    checks++; if (addr_bad != 0) begin errors++; $display("FAIL scan_addr_track: %0d bad cycles, required 0", addr_bad); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL scan_busy_track: %0d bad cycles, required 0", busy_bad); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scan_frames_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int dn [$];
    int second_low;
    logic busy_idle, busy_rearm;
    load_mem(8'h55, 8'hA3, 8'h00, 8'hFF);
    push_scan(8'h55, 8'hA3, 8'h00, 8'hFF);
    push_scan(8'h55, 8'hA3, 8'h00, 8'hFF);
    second_low = -1; busy_idle = 1'bx; busy_rearm = 1'bx;
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 2 * SCAN + 10; n++) begin
      @(negedge clk);
      if (n == 200) start = 1'b0;
      if (done === 1'b1) dn.push_back(n);
      if (n == SCAN + 1) busy_idle = busy;
      if (n == SCAN + 2) busy_rearm = busy;
      if (n > SCAN && tx === 1'b0 && second_low < 0) second_low = n;
    end
    checks++; if (dn.size() != 2) begin errors++; $display("FAIL b2b_done_count: got %0d, required 2", dn.size()); end
    checks++; if (dn.size() == 2 && dn[1] != 2 * SCAN + 2) begin errors++; $display("FAIL b2b_second_done: got %0d, required %0d", dn[1], 2 * SCAN + 2); end
    checks++; if (busy_idle !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy %b, required 0", busy_idle); end
    checks++; if (busy_rearm !== 1'b1) begin errors++; $display("FAIL b2b_rearm: busy %b, required 1", busy_rearm); end
    // IDLE occupies edge SCAN+1; tx falls two edges later
    checks++; if (second_low != SCAN + 3) begin errors++; $display("FAIL b2b_latency: got %0d, required %0d", second_low, SCAN + 3); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_frames_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_write_in_flight();
    int done_cnt;
    load_mem(8'h55, 8'hA3, 8'h00, 8'hFF);
    push_scan(8'h55, 8'h3C, 8'h00, 8'hFF);
    done_cnt = 0;
    fire_start();
    for (int n = 0; n <= SCAN + 3; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 10) mem[1] = 8'h3C;              // entry 0 still in its data bits
      if (n == WC + 1 + CPB + 4) mem[1] = 8'h99; // entry 1 in its data bits
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL wr_done_count: got %0d, required 1", done_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wr_frames_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    int done_cnt;
    load_mem(8'h55, 8'hA3, 8'h00, 8'hFF);
    exp_q.push_back('{addr: 2'd0, data: 8'h55});
    exp_q.push_back('{addr: 2'd1, data: 8'hA3});
    fire_start();
    // Entry 2 fetches at 2*WC; land a few bits into its data
    repeat (2 * WC + 1 + CPB + 10) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL mid_rst_tx: got %b, required 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
    checks++; if (read_address !== 2'd0) begin errors++; $display("FAIL mid_rst_addr: got %0d, required 0", read_address); end
    done_cnt = 0;
    for (int n = 0; n < 5; n++) begin @(negedge clk); if (done === 1'b1) done_cnt++; end
    reset = 1'b1;
    for (int n = 0; n < 50; n++) begin @(negedge clk); if (done === 1'b1) done_cnt++; end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL mid_rst_done: %0d pulses, required 0", done_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_rst_frames_left: got %0d, required 0", exp_q.size()); end
    push_scan(8'h55, 8'hA3, 8'h00, 8'hFF);
    fire_start();
    checks++; if (read_address !== 2'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL rescan_begin: addr=%0d busy=%b, required addr=0 busy=1", read_address, busy);
    end
    done_cnt = 0;
    for (int n = 1; n <= SCAN + 3; n++) begin @(negedge clk); if (done === 1'b1) done_cnt++; end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rescan_done_count: got %0d, required 1", done_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rescan_frames_left: got %0d, required 0", exp_q.size()); end
  endtask

`ifdef REGFILE_READER_PARITY_EN
  task automatic test_parity();
    load_mem(8'hA3, 8'h01, 8'h00, 8'hFF);
    push_scan(8'hA3, 8'h01, 8'h00, 8'hFF);
    fire_start();
    repeat (SCAN + 3) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL par_frames_left: got %0d, required 0", exp_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL par_busy_end: got %b, required 0", busy); end
  endtask
`endif

  initial begin
    load_mem(8'h55, 8'hA3, 8'h00, 8'hFF);
    test_reset();
    test_scan();
    test_back_to_back();
    test_write_in_flight();
    test_reset_midframe();
`ifdef REGFILE_READER_PARITY_EN
    test_parity();
`endif
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
